// File: rtl/cpu_clk_ctrl_if.sv
// -----------------------------------------------------------------------------
// cpu_clk_ctrl_if
// Purpose : groups the board-facing switch/halt inputs and the CPU enable/mode
//           outputs of cpu_clk_ctrl into one bundle.
// Signals : i_Mode_Switch - raw mode button (active-high)
//           i_Step_Switch - raw step button (active-high)
//           i_Halt        - synchronous halt level from the CPU
//           o_Cpu_Clk_En  - single-cycle CPU clock-enable pulse
//           o_Run_Mode    - 1 = RUN, 0 = STEP
// Modports: master - board/bench side (drives switches and halt)
//           slave  - cpu_clk_ctrl side (drives enable and mode)
// -----------------------------------------------------------------------------
interface cpu_clk_ctrl_if;
    logic i_Mode_Switch;
    logic i_Step_Switch;
    logic i_Halt;
    logic o_Cpu_Clk_En;
    logic o_Run_Mode;

    modport master (
        output i_Mode_Switch,
        output i_Step_Switch,
        output i_Halt,
        input  o_Cpu_Clk_En,
        input  o_Run_Mode
    );

    modport slave (
        input  i_Mode_Switch,
        input  i_Step_Switch,
        input  i_Halt,
        output o_Cpu_Clk_En,
        output o_Run_Mode
    );
endinterface

// File: rtl/cpu_clk_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_clk_ctrl
// Purpose : generates a one-cycle CPU clock-enable pulse in the i_Clk domain.
//           RUN mode pulses every CLKS_PER_TICK cycles; STEP mode pulses once
//           per debounced step-button press. i_Halt suppresses all pulses.
// Ports   : i_Clk   - main clock, all state on posedge
//           i_Reset - asynchronous active-high reset
//           bus     - cpu_clk_ctrl_if.slave (switches, halt, enable, mode)
// Params  : CLKS_PER_TICK - RUN-mode pulse period in i_Clk cycles (>= 2)
//           DEBOUNCE_CLKS - stable cycles before a debounced level changes (>= 1)
// Macro   : CPU_CLK_DEBOUNCE_EN - when defined, each switch is debounced;
//           when undefined, the debounced level is the synchronized level
//           registered once and DEBOUNCE_CLKS is not used by the logic.
// -----------------------------------------------------------------------------
module cpu_clk_ctrl #(
    parameter int CLKS_PER_TICK = 2097152,
    parameter int DEBOUNCE_CLKS = 250000
) (
    input  logic          i_Clk,
    input  logic          i_Reset,
    cpu_clk_ctrl_if.slave bus
);

    // Bit positions of the two switches in the per-switch vectors
    localparam int SW_MODE = 0;
    localparam int SW_STEP = 1;

    localparam int                TICK_W    = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_TICK - 1);

    typedef enum logic [0:0] {
        ST_STEP = 1'b0,
        ST_RUN  = 1'b1
    } mode_state_e;

    // Elaboration-time parameter guards
    if (CLKS_PER_TICK < 2) begin : g_bad_tick
        $error("cpu_clk_ctrl: CLKS_PER_TICK must be at least 2");
    end
    if (DEBOUNCE_CLKS < 1) begin : g_bad_debounce
        $error("cpu_clk_ctrl: DEBOUNCE_CLKS must be at least 1");
    end

    logic [1:0]        raw_s;
    logic [1:0]        sync1_r;
    logic [1:0]        sync2_r;
    logic [1:0]        deb_r;
    logic [1:0]        deb_prev_r;
    logic [1:0]        press_s;
    mode_state_e       state_r;
    mode_state_e       state_next_s;
    logic [TICK_W-1:0] tick_r;
    logic [TICK_W-1:0] tick_next_s;
    logic              en_r;
    logic              en_next_s;

    assign raw_s = {bus.i_Step_Switch, bus.i_Mode_Switch};

    // Two-flop synchronizer for both raw switches
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

`ifdef CPU_CLK_DEBOUNCE_EN
    localparam int               DEB_W    = (DEBOUNCE_CLKS > 1) ? $clog2(DEBOUNCE_CLKS) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CLKS - 1);

    logic [DEB_W-1:0] deb_cnt_r [2];

    // Per-switch debouncer: the level only follows the synchronized value
    // after it has disagreed for DEBOUNCE_CLKS consecutive cycles
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            deb_r <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                deb_cnt_r[i] <= {DEB_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] != deb_r[i]) begin
                    if (deb_cnt_r[i] == DEB_LAST) begin
                        deb_r[i]     <= sync2_r[i];
                        deb_cnt_r[i] <= {DEB_W{1'b0}};
                    end else begin
                        deb_cnt_r[i] <= deb_cnt_r[i] + DEB_W'(1);
                    end
                end else begin
                    deb_cnt_r[i] <= {DEB_W{1'b0}};
                end
            end
        end
    end
`else
    // Debounce bypassed: the level is the synchronized value, one register later
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            deb_r <= 2'b00;
        end else begin
            deb_r <= sync2_r;
        end
    end
`endif

    // History of the debounced levels for rising-edge detection
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            deb_prev_r <= 2'b00;
        end else begin
            deb_prev_r <= deb_r;
        end
    end

    // Press strobes: debounced 0->1 only; releases produce nothing
    assign press_s = deb_r & ~deb_prev_r;

    // Mode state register
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next mode: every mode press toggles, regardless of halt
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (press_s[SW_MODE]) begin
                    state_next_s = ST_STEP;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_STEP: begin
                if (press_s[SW_MODE]) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_STEP;
                end
            end
            default: state_next_s = ST_RUN;
        endcase
    end

    // Next tick count and enable. The decision uses the pre-toggle state, so a
    // mode press in RUN clears the counter and suppresses the pulse, while a
    // step press coinciding with a mode press in STEP still produces a pulse.
    always_comb begin
        tick_next_s = {TICK_W{1'b0}};
        en_next_s   = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (bus.i_Halt || press_s[SW_MODE]) begin
                    tick_next_s = {TICK_W{1'b0}};
                    en_next_s   = 1'b0;
                end else if (tick_r == TICK_LAST) begin
                    tick_next_s = {TICK_W{1'b0}};
                    en_next_s   = 1'b1;
                end else begin
                    tick_next_s = tick_r + TICK_W'(1);
                    en_next_s   = 1'b0;
                end
            end
            ST_STEP: begin
                tick_next_s = {TICK_W{1'b0}};
                if (!bus.i_Halt && press_s[SW_STEP]) begin
                    en_next_s = 1'b1;
                end else begin
                    en_next_s = 1'b0;
                end
            end
            default: begin
                tick_next_s = {TICK_W{1'b0}};
                en_next_s   = 1'b0;
            end
        endcase
    end

    // Tick counter and enable output registers
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            tick_r <= {TICK_W{1'b0}};
            en_r   <= 1'b0;
        end else begin
            tick_r <= tick_next_s;
            en_r   <= en_next_s;
        end
    end

    assign bus.o_Cpu_Clk_En = en_r;
    assign bus.o_Run_Mode   = (state_r == ST_RUN);

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_clk_ctrl
// Bench for cpu_clk_ctrl with CLKS_PER_TICK = 8 and DEBOUNCE_CLKS = 4.
// The reference model works on per-cycle input history: a debounced level
// flips once the synchronized input (raw input two cycles earlier) has shown
// the opposite value for the last DEBOUNCE_CLKS samples; RUN pulses fall on
// every CLKS_PER_TICK-th cycle since counting last (re)started.
// -----------------------------------------------------------------------------
module tb_cpu_clk_ctrl;

    localparam int CPT  = 8;
    localparam int DEB  = 4;
`ifdef CPU_CLK_DEBOUNCE_EN
    localparam int DEB_EFF = DEB;
`else
    localparam int DEB_EFF = 1;
`endif
    localparam int HMAX = 4096;
    localparam int GLITCH_EXP = (DEB_EFF > 3) ? 0 : 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int tests_run    = 0;
    int tests_failed = 0;

    int   obs_pulses = 0;
    int   run_falls  = 0;
    int   run_rises  = 0;
    logic prev_run   = 1'b1;

    // Reference model state
    logic hist [2][HMAX];
    logic m_deb  [2];
    logic m_rise [2];
    logic m_run;
    logic m_en;
    int   m_t;
    int   m_start;

    cpu_clk_ctrl_if bus ();

    cpu_clk_ctrl #(
        .CLKS_PER_TICK(CPT),
        .DEBOUNCE_CLKS(DEB)
    ) dut (
        .i_Clk  (clk),
        .i_Reset(rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic cmp_bit(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0b expected %0b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cmp_int(input string tag, input int obs, input int exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_deb[0]  = 1'b0;
        m_deb[1]  = 1'b0;
        m_rise[0] = 1'b0;
        m_rise[1] = 1'b0;
        m_run     = 1'b1;
        m_en      = 1'b0;
        m_t       = 0;
        m_start   = 0;
        prev_run  = 1'b1;
    endfunction

    // True when the last DEB_EFF synchronized samples of switch sw all equal v
    function automatic logic window_all(input int sw, input int t, input logic v);
        int   idx;
        logic s;
        for (int k = 0; k < DEB_EFF; k++) begin
            idx = t - 2 - k;
            s   = (idx >= 0) ? hist[sw][idx] : 1'b0;
            if (s !== v) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void model_edge(input logic mode_v, input logic step_v, input logic halt_v);
        logic press_m;
        logic press_s;
        logic pulse;
        logic nxt;
        if (m_t < HMAX) begin
            hist[0][m_t] = mode_v;
            hist[1][m_t] = step_v;
        end
        press_m = m_rise[0];
        press_s = m_rise[1];
        for (int sw = 0; sw < 2; sw++) begin
            nxt = m_deb[sw];
            if (window_all(sw, m_t, ~m_deb[sw])) nxt = ~m_deb[sw];
            m_rise[sw] = ~m_deb[sw] & nxt;
            m_deb[sw]  = nxt;
        end
        pulse = 1'b0;
        if (m_run && !halt_v && !press_m) begin
            if (((m_t - m_start + 1) % CPT) == 0) pulse = 1'b1;
        end else begin
            m_start = m_t + 1;
        end
        if (!m_run && !halt_v && press_s) pulse = 1'b1;
        if (press_m) m_run = ~m_run;
        m_en = pulse;
        m_t++;
    endfunction

    task automatic tick(input logic mode_v, input logic step_v, input logic halt_v);
        bus.i_Mode_Switch = mode_v;
        bus.i_Step_Switch = step_v;
        bus.i_Halt        = halt_v;
        @(posedge clk);
        model_edge(mode_v, step_v, halt_v);
        #1;
        cmp_bit("cpu_clk_en", bus.o_Cpu_Clk_En, m_en);
        cmp_bit("run_mode", bus.o_Run_Mode, m_run);
        if (bus.o_Cpu_Clk_En === 1'b1) obs_pulses++;
        if (prev_run === 1'b1 && bus.o_Run_Mode === 1'b0) run_falls++;
        if (prev_run === 1'b0 && bus.o_Run_Mode === 1'b1) run_rises++;
        prev_run = bus.o_Run_Mode;
    endtask

    initial begin
        int   first;
        int   p0;
        int   f0;
        int   pulse_at;
        int   rise_at;
        int   n;
        int   hold_m;
        int   hold_s;
        int   hold_h;
        logic rm;
        logic rs;
        logic rh;
        logic found;

        bus.i_Mode_Switch = 1'b0;
        bus.i_Step_Switch = 1'b0;
        bus.i_Halt        = 1'b0;

        // Reset values
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cmp_bit("rst_en", bus.o_Cpu_Clk_En, 1'b0);
        cmp_bit("rst_run", bus.o_Run_Mode, 1'b1);
        #3 rst = 1'b0;
        model_reset();

        // Free-running RUN pulses
        first = -1;
        p0    = obs_pulses;
        for (int i = 1; i <= 32; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            if (bus.o_Cpu_Clk_En === 1'b1 && first < 0) first = i;
        end
        cmp_int("first_pulse", first, CPT);
        cmp_int("run_pulses", obs_pulses - p0, 32 / CPT);

        // Mode press: RUN -> STEP exactly once, then silence
        f0 = run_falls;
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b0);
        p0 = obs_pulses;
        for (int i = 0; i < 14; i++) tick(1'b0, 1'b0, 1'b0);
        cmp_int("mode_falls", run_falls - f0, 1);
        cmp_int("step_idle_pulses", obs_pulses - p0, 0);
        cmp_bit("in_step", bus.o_Run_Mode, 1'b0);

        // Three held step presses, one pulse each
        f0 = obs_pulses;
        for (int p = 0; p < 3; p++) begin
            p0 = obs_pulses;
            for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 1'b0);
            for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b0);
            cmp_int("step_press", obs_pulses - p0, 1);
        end
        cmp_int("step_total", obs_pulses - f0, 3);

        // Short glitch on the step switch
        p0 = obs_pulses;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, 1'b0);
        cmp_int("glitch_pulses", obs_pulses - p0, GLITCH_EXP);

        // Back to RUN, then halt
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0);
        cmp_bit("back_to_run", bus.o_Run_Mode, 1'b1);
        p0 = obs_pulses;
        for (int i = 0; i < 30; i++) tick(1'b0, 1'b0, 1'b1);
        cmp_int("halt_pulses", obs_pulses - p0, 0);
        first = -1;
        for (int i = 1; i <= 20; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            if (bus.o_Cpu_Clk_En === 1'b1 && first < 0) first = i;
        end
        cmp_int("halt_first", first, CPT);

        // Coincident mode and step presses while in STEP
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 1'b0);
        cmp_bit("coinc_pre_step", bus.o_Run_Mode, 1'b0);
        pulse_at = -1;
        rise_at  = -1;
        f0       = run_rises;
        for (int i = 1; i <= 24; i++) begin
            if (i <= 10) tick(1'b1, 1'b1, 1'b0);
            else         tick(1'b0, 1'b0, 1'b0);
            if (bus.o_Cpu_Clk_En === 1'b1 && pulse_at < 0) pulse_at = i;
            if (run_rises != f0 && rise_at < 0) rise_at = i;
        end
        cmp_int("coinc_pulse_at", pulse_at, DEB_EFF + 3);
        cmp_int("coinc_align", rise_at, pulse_at);
        cmp_bit("coinc_run", bus.o_Run_Mode, 1'b1);

        // Randomized held switch levels and halt
        hold_m = 0;
        hold_s = 0;
        hold_h = 0;
        rm = 1'b0;
        rs = 1'b0;
        rh = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (hold_m == 0) begin
                rm     = 1'($urandom_range(0, 1));
                hold_m = int'($urandom_range(1, 12));
            end
            if (hold_s == 0) begin
                rs     = 1'($urandom_range(0, 1));
                hold_s = int'($urandom_range(1, 12));
            end
            if (hold_h == 0) begin
                rh     = ($urandom_range(0, 5) == 0);
                hold_h = int'($urandom_range(1, 15));
            end
            tick(rm, rs, rh);
            hold_m--;
            hold_s--;
            hold_h--;
        end
        for (int i = 0; i < 16; i++) tick(1'b0, 1'b0, 1'b0);

        // Asynchronous reset while a pulse is out and a mode debounce is running
        if (m_run) begin
            for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 1'b0);
        end
        found = 1'b0;
        n     = 0;
        while (!found && n < 30) begin
            n++;
            tick((n >= 3), 1'b1, 1'b0);
            if (bus.o_Cpu_Clk_En === 1'b1) found = 1'b1;
        end
        cmp_int("step_seen", int'(found), 1);
        cmp_bit("pre_rst_run", bus.o_Run_Mode, 1'b0);
        #2 rst = 1'b1;
        #1;
        cmp_bit("async_en", bus.o_Cpu_Clk_En, 1'b0);
        cmp_bit("async_run", bus.o_Run_Mode, 1'b1);
        bus.i_Mode_Switch = 1'b0;
        bus.i_Step_Switch = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        model_reset();
        first = -1;
        for (int i = 1; i <= 12; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            if (bus.o_Cpu_Clk_En === 1'b1 && first < 0) first = i;
        end
        cmp_int("post_rst_first", first, CPT);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cpu_clk_ctrl.md
Name: cpu_clk_ctrl

Overview:
Upstream of the CPU core on the Go Board top level. It replaces the free-running divided clock with a single-cycle clock-enable pulse, o_Cpu_Clk_En, in the i_Clk domain.
- Two modes: RUN (periodic pulses) and STEP (one pulse per debounced button press).
- Mode and step buttons are raw board switches, synchronized and debounced here.
- A halt input from the CPU suppresses all pulses.

Parameters:
CLKS_PER_TICK, 2097152, i_Clk cycles between enable pulses in RUN mode (2^21 ≈ 12 Hz at 25 MHz); must be ≥ 2
DEBOUNCE_CLKS, 250000, consecutive stable cycles before a debounced switch level changes (10 ms at 25 MHz); must be ≥ 1

Ports:
i_Clk  input  1  main 25 MHz clock; all state on posedge
i_Reset  input  1  asynchronous, active-high reset
i_Mode_Switch  input  1  raw mode button, active-high; each press toggles RUN/STEP
i_Step_Switch  input  1  raw step button, active-high; each press issues one pulse in STEP mode
i_Halt  input  1  synchronous level from CPU; high suppresses all pulses
o_Cpu_Clk_En  output  1  one-i_Clk-cycle enable pulse to the CPU
o_Run_Mode  output  1  1 = RUN, 0 = STEP

Behaviour:
- Reset (async assert, sync use):
  - o_Cpu_Clk_En = 0, o_Run_Mode = 1.
  - Tick counter = 0; debounce counters = 0.
  - Synchronizer flops and debounced levels = 0; edge-detect history = 0.
  - Reset mid-operation aborts any pending pulse or debounce in progress.
- Input synchronizer: each raw switch passes through a 2-flop synchronizer before any other use.
- Debouncer, per switch:
  - Counter increments each cycle the synchronized level differs from the debounced level.
  - Counter clears whenever the two levels match.
  - When the counter reaches DEBOUNCE_CLKS-1 while still differing, the debounced level takes the synchronized value and the counter clears.
  - Glitches shorter than DEBOUNCE_CLKS cycles are ignored.
- Press event: one-cycle strobe on a debounced 0→1 transition. Release (1→0) produces no event.
- Mode FSM, states RUN and STEP:
  - A mode press event toggles the state on the next clock edge.
  - o_Run_Mode is the registered state.
- RUN mode:
  - Tick counter counts 0..CLKS_PER_TICK-1 and wraps to 0.
  - o_Cpu_Clk_En = 1 for exactly the cycle following the counter value CLKS_PER_TICK-1.
  - Pulse period is exactly CLKS_PER_TICK cycles.
- STEP mode:
  - Tick counter is held at 0.
  - Each step press event produces o_Cpu_Clk_En = 1 on the next cycle, exactly one pulse per press.
  - Holding the button gives no further pulses.
- Mode changes:
  - STEP→RUN: counter restarts from 0; first pulse appears CLKS_PER_TICK cycles after o_Run_Mode rises.
  - RUN→STEP: counter is cleared; no pulse is issued in the cycle after the transition.
- Simultaneous mode press and step press in the same cycle:
  - The step press is honoured only if the current (pre-toggle) state is STEP.
  - The mode toggle always takes effect.
- i_Halt high:
  - o_Cpu_Clk_En forced 0.
  - Tick counter held at 0.
  - Step press events are discarded, not queued.
  - The mode FSM still toggles.
  - After i_Halt falls in RUN mode, the first pulse follows after CLKS_PER_TICK cycles.
- Pulses are never back-to-back except when CLKS_PER_TICK = 1, which is disallowed.
- Width rules: counters sized with $clog2 of their parameter, with a minimum width of 1; comparisons are unsigned.

Optional Feature:
Macro CPU_CLK_DEBOUNCE_EN.
- Defined: debouncers present as above.
- Undefined:
  - Debouncers are omitted; the debounced level equals the synchronized level.
  - Press events occur 1 cycle after the synchronized rising edge.
  - DEBOUNCE_CLKS is ignored.
  - Intended for fast simulation and benches with clean stimulus.

Test Plan:
- Bench parameters CLKS_PER_TICK=8, DEBOUNCE_CLKS=4, macro defined.
- Reset release, no input → o_Run_Mode=1; o_Cpu_Clk_En pulses every 8 cycles, each 1 cycle wide; first pulse 8 cycles after reset deassert.
- Mode switch high for 10 cycles → o_Run_Mode falls exactly once; no pulses afterwards.
- In STEP, step switch high for 20 cycles → exactly one pulse. Repeat three presses → three pulses total.
- In STEP, step switch high for 3 cycles then low (glitch) → no pulse; debounced level unchanged.
- In RUN, i_Halt high for 30 cycles → no pulses. After i_Halt falls, first pulse 8 cycles later.
- Mode and step debounced edges arranged to coincide while in STEP → one pulse, then o_Run_Mode=1. i_Reset pulsed mid-debounce → all outputs return to reset values immediately (asynchronous).
